eprisc_gpio_v2: RTL and testbench

Parametrised second-generation epRISC GPIO controller. It provides `WIDTH` bidirectional pins, each with its own direction control. Inputs pass through a synchroniser. Each pin has a per-pin interrupt that can be level- or edge-triggered, with selectable polarity. Interrupt status is sticky and cleared by writing 1 (write-1-to-clear, W1C). The block sits on the epRISC I/O bus as a slave and drives one interrupt line to the interrupt controller.

---
 rtl/eprisc_gpio_v2.sv | 153 +++++++++++++++
 tb/tb_eprisc_gpio_v2.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eprisc_gpio_v2.sv
// epRISC GPIO controller, second generation: per-pin direction, synchronised inputs,
// level/edge interrupts with selectable polarity, sticky W1C status and one registered IRQ.
module eprisc_gpio_v2 #(
  parameter int WIDTH       = 16,
  parameter int BUS_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iEnable,
  input  logic             iWrite,
  input  logic [2:0]       iAddress,
  input  logic [BUS_W-1:0] iData,
  output logic [BUS_W-1:0] oData,
  output logic             oInterrupt,
  inout  wire  [WIDTH-1:0] bPort
);

  localparam int CW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [0:0] {ARMING = 1'b0, ARMED = 1'b1} armState_t;

  armState_t         armState, armStateNext;
  logic [CW-1:0]     armCount, armCountNext;
  logic              armed;

  logic [WIDTH-1:0]  dirReg, outReg, ienReg, itypeReg, ipolReg, istatReg;
  logic [WIDTH-1:0]  syncReg [SYNC_STAGES];
  logic [WIDTH-1:0]  prevReg;
  logic              interruptReg;

  logic [WIDTH-1:0]  inSync, wrData, clearMask, eventMask;
  logic [BUS_W-1:0]  readData;
  logic              writeEn, readEn;
  logic              unusedData;

  assign wrData     = iData[WIDTH-1:0];
  assign unusedData = ^iData;
  assign writeEn    = iEnable && iWrite;
  assign readEn     = iEnable && !iWrite;
  assign inSync     = syncReg[SYNC_STAGES-1];
  assign oInterrupt = interruptReg;
  assign oData      = readEn ? readData : {BUS_W{1'bz}};

  for (genvar g = 0; g < WIDTH; g++) begin : gPin
    assign bPort[g] = dirReg[g] ? outReg[g] : 1'bz;
  end

  // Arming state register
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      armState <= ARMING;
      armCount <= '0;
    end else begin
      armState <= armStateNext;
      armCount <= armCountNext;
    end
  end

  // Arming next state: leave ARMING once SYNC_STAGES+1 edges have elapsed
  always_comb begin
    armStateNext = armState;
    case (armState)
      ARMING: begin
        if (armCount == CW'(SYNC_STAGES)) armStateNext = ARMED;
        else                              armStateNext = ARMING;
      end
      ARMED:   armStateNext = ARMED;
      default: armStateNext = ARMING;
    endcase
  end

  // Arming outputs: counter advances while arming, saturates once armed
  always_comb begin
    armed        = 1'b0;
    armCountNext = armCount;
    if (armState == ARMED) begin
      armed        = 1'b1;
      armCountNext = armCount;
    end else begin
      armed        = 1'b0;
      armCountNext = armCount + CW'(1);
    end
  end

  // Input synchroniser plus previous-value flop for edge detection
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncReg[i] <= '0;
      prevReg <= '0;
    end else begin
      syncReg[0] <= bPort;
      for (int i = 1; i < SYNC_STAGES; i++) syncReg[i] <= syncReg[i-1];
      prevReg <= inSync;
    end
  end

  // Per-pin event detection and W1C mask
  always_comb begin
    eventMask = '0;
    clearMask = '0;
    if (armed) begin
      eventMask = ~dirReg & ~(inSync ^ ipolReg) & (~itypeReg | (inSync ^ prevReg));
    end else begin
      eventMask = '0;
    end
    if (writeEn && (iAddress == 3'd6)) clearMask = wrData;
    else                                clearMask = '0;
  end

  // Control registers, sticky status (set beats clear) and registered IRQ
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      dirReg       <= '0;
      outReg       <= '0;
      ienReg       <= '0;
      itypeReg     <= '0;
      ipolReg      <= '0;
      istatReg     <= '0;
      interruptReg <= 1'b0;
    end else begin
      if (writeEn) begin
        case (iAddress)
          3'd0:    dirReg   <= wrData;
          3'd1:    outReg   <= wrData;
          3'd3:    ienReg   <= wrData;
          3'd4:    itypeReg <= wrData;
          3'd5:    ipolReg  <= wrData;
          3'd7:    outReg   <= outReg ^ wrData;
          default: ;
        endcase
      end
      istatReg     <= (istatReg & ~clearMask) | eventMask;
      interruptReg <= |(istatReg & ienReg);
    end
  end

  // Combinational read mux; unimplemented upper bits read 0
  always_comb begin
    readData = '0;
    case (iAddress)
      3'd0:    readData[WIDTH-1:0] = dirReg;
      3'd1:    readData[WIDTH-1:0] = outReg;
      3'd2:    readData[WIDTH-1:0] = inSync;
      3'd3:    readData[WIDTH-1:0] = ienReg;
      3'd4:    readData[WIDTH-1:0] = itypeReg;
      3'd5:    readData[WIDTH-1:0] = ipolReg;
      3'd6:    readData[WIDTH-1:0] = istatReg;
      default: readData = '0;
    endcase
  end

endmodule

// File: tb/tb_eprisc_gpio_v2.sv
// Directed bench for eprisc_gpio_v2 (WIDTH=16, BUS_W=32, SYNC_STAGES=2).
module tb_eprisc_gpio_v2;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iEnable = 1'b0;
  logic        iWrite = 1'b0;
  logic [2:0]  iAddress = 3'd0;
  logic [31:0] iData = 32'h0;
  wire  [31:0] oData;
  wire         oInterrupt;
  wire  [15:0] bPort;

  logic [15:0] tbOe  = 16'hFFFF;
  logic [15:0] tbVal = 16'hFFFF;
  logic [31:0] rd;
  int          checks = 0;
  int          errors = 0;

  for (genvar g = 0; g < 16; g++) begin : gDrv
    assign bPort[g] = tbOe[g] ? tbVal[g] : 1'bz;
  end

  eprisc_gpio_v2 dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iWrite(iWrite),
    .iAddress(iAddress), .iData(iData), .oData(oData),
    .oInterrupt(oInterrupt), .bPort(bPort)
  );

  always #5 iClock = ~iClock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    @(negedge iClock);
    iEnable = 1'b1; iWrite = 1'b1; iAddress = a; iData = d;
    @(posedge iClock);
    #1;
    iEnable = 1'b0; iWrite = 1'b0;
  endtask

  task automatic busRead(input logic [2:0] a, output logic [31:0] d);
    iEnable = 1'b1; iWrite = 1'b0; iAddress = a;
    #1;
    d = oData;
    iEnable = 1'b0;
  endtask

  task automatic test_reset;
    iReset = 1'b0;
    repeat (3) @(posedge iClock);
    #1;
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b expected 0", oInterrupt);
    end
    for (int a = 0; a < 8; a++) begin
      busRead(3'(a), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected 00000000", a, rd);
      end
    end
    @(negedge iClock);
    iReset = 1'b1;
    repeat (6) @(posedge iClock);
    #1;
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL reset_no_istat: got %h expected 00000000", rd);
    end
    busRead(3'd2, rd);
    checks++;
    if (rd !== 32'h0000_FFFF) begin
      errors++; $display("FAIL reset_in_hiz: got %h expected 0000ffff", rd);
    end
  endtask

  task automatic test_output_path;
    tbOe = 16'hFF00;
    busWrite(3'd0, 32'h0000_00FF);
    busWrite(3'd1, 32'h0000_00A5);
    busWrite(3'd7, 32'h0000_000F);
    checks++;
    if (bPort[7:0] !== 8'hAA) begin
      errors++; $display("FAIL pin_drive: got %h expected aa", bPort[7:0]);
    end
    busRead(3'd1, rd);
    checks++;
    if (rd !== 32'h0000_00AA) begin
      errors++; $display("FAIL out_readback: got %h expected 000000aa", rd);
    end
    busRead(3'd7, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL outtgl_read: got %h expected 00000000", rd);
    end
    repeat (3) @(posedge iClock);
    #1;
    busRead(3'd2, rd);
    checks++;
    if (rd !== 32'h0000_FFAA) begin
      errors++; $display("FAIL in_pad_value: got %h expected 0000ffaa", rd);
    end
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL outputs_no_event: got %h expected 00000000", rd);
    end
    // back to inputs: stale low IN bits are valid level-low events across the switch
    busWrite(3'd0, 32'h0);
    tbOe = 16'hFFFF;
    repeat (3) @(posedge iClock);
    #1;
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0000_0055) begin
      errors++; $display("FAIL dir_switch_event: got %h expected 00000055", rd);
    end
    busWrite(3'd6, 32'hFFFF_FFFF);
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL w1c_all: got %h expected 00000000", rd);
    end
    busWrite(3'd3, 32'hFFFF_FFFF);
    busRead(3'd3, rd);
    checks++;
    if (rd !== 32'h0000_FFFF) begin
      errors++; $display("FAIL upper_bits: got %h expected 0000ffff", rd);
    end
    busWrite(3'd3, 32'h0);
  endtask

  task automatic test_rising_edge;
    busWrite(3'd4, 32'h1);
    busWrite(3'd5, 32'h1);
    busWrite(3'd3, 32'h1);
    @(negedge iClock);
    tbVal[0] = 1'b0;
    repeat (4) @(posedge iClock);
    #1;
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL falling_ignored: got %h expected 00000000", rd);
    end
    @(negedge iClock);
    tbVal[0] = 1'b1;
    @(posedge iClock);           // edge k
    @(posedge iClock); #1;       // k+1
    busRead(3'd2, rd);
    checks++;
    if (rd[0] !== 1'b1) begin
      errors++; $display("FAIL in_latency: got %b expected 1", rd[0]);
    end
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL istat_early: got %h expected 00000000", rd);
    end
    @(posedge iClock); #1;       // k+2
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h1 || oInterrupt !== 1'b0) begin
      errors++; $display("FAIL edge_k2: got istat %h irq %b expected 00000001 0", rd, oInterrupt);
    end
    @(posedge iClock); #1;       // k+3
    checks++;
    if (oInterrupt !== 1'b1) begin
      errors++; $display("FAIL irq_k3: got %b expected 1", oInterrupt);
    end
    busWrite(3'd6, 32'h1);
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0 || oInterrupt !== 1'b1) begin
      errors++; $display("FAIL w1c_edge: got istat %h irq %b expected 00000000 1", rd, oInterrupt);
    end
    @(posedge iClock); #1;
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL irq_drop: got %b expected 0", oInterrupt);
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 2; n++) begin
      @(negedge iClock); tbVal[0] = 1'b0;
      repeat (3) @(posedge iClock);
      @(negedge iClock); tbVal[0] = 1'b1;
      repeat (3) @(posedge iClock);
    end
    #1;
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL two_edges_sticky: got %h expected 00000001", rd);
    end
    busWrite(3'd6, 32'h1);
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL two_edges_clear: got %h expected 00000000", rd);
    end
    repeat (2) @(posedge iClock);
  endtask

  task automatic test_level_low;
    busWrite(3'd3, 32'h4);
    @(negedge iClock);
    tbVal[2] = 1'b0;
    repeat (4) @(posedge iClock);
    #1;
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h4 || oInterrupt !== 1'b1) begin
      errors++; $display("FAIL level_set: got istat %h irq %b expected 00000004 1", rd, oInterrupt);
    end
    busWrite(3'd6, 32'h4);
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h4) begin
      errors++; $display("FAIL level_set_wins: got %h expected 00000004", rd);
    end
    @(negedge iClock);
    tbVal[2] = 1'b1;
    repeat (4) @(posedge iClock);
    busWrite(3'd6, 32'h4);
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL level_clear: got %h expected 00000000", rd);
    end
    @(posedge iClock); #1;
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL level_irq_drop: got %b expected 0", oInterrupt);
    end
  endtask

  task automatic test_masking;
    busWrite(3'd3, 32'h0);
    busWrite(3'd4, 32'h21);
    busWrite(3'd5, 32'h21);
    @(negedge iClock); tbVal[5] = 1'b0;
    repeat (4) @(posedge iClock);
    @(negedge iClock); tbVal[5] = 1'b1;
    repeat (4) @(posedge iClock);
    #1;
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h20 || oInterrupt !== 1'b0) begin
      errors++; $display("FAIL masked_event: got istat %h irq %b expected 00000020 0", rd, oInterrupt);
    end
    busWrite(3'd3, 32'h20);
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL ien_irq_same: got %b expected 0", oInterrupt);
    end
    @(posedge iClock); #1;
    checks++;
    if (oInterrupt !== 1'b1) begin
      errors++; $display("FAIL ien_irq_next: got %b expected 1", oInterrupt);
    end
  endtask

  task automatic test_mid_reset;
    tbOe[15] = 1'b0;
    busWrite(3'd0, 32'h8000);
    busRead(3'd0, rd);
    checks++;
    if (rd !== 32'h8000 || oInterrupt !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got dir %h irq %b expected 00008000 1", rd, oInterrupt);
    end
    #2;
    iReset = 1'b0;
    tbOe[15] = 1'b1;
    #1;
    checks++;
    if (oInterrupt !== 1'b0) begin
      errors++; $display("FAIL async_irq: got %b expected 0", oInterrupt);
    end
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL async_istat: got %h expected 00000000", rd);
    end
    busRead(3'd0, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL async_dir: got %h expected 00000000", rd);
    end
    repeat (2) @(posedge iClock);
    @(negedge iClock);
    iReset = 1'b1;
    busWrite(3'd4, 32'h20);
    busWrite(3'd5, 32'h20);
    repeat (6) @(posedge iClock);
    #1;
    busRead(3'd6, rd);
    checks++;
    if (rd !== 32'h0 || oInterrupt !== 1'b0) begin
      errors++; $display("FAIL arming_quiet: got istat %h irq %b expected 00000000 0", rd, oInterrupt);
    end
  endtask

  initial begin
    test_reset();
    test_output_path();
    test_rising_edge();
    test_back_to_back();
    test_level_low();
    test_masking();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
